baud_gen_frac: RTL

Programmable fractional baud-rate generator for the UART. Produces an oversampling tick (OSR ticks per bit) for the receiver, a bit tick and a square bit clock for the transmitter, and a mid-bit sample strobe. The divisor has integer and fractional parts and is loadable at runtime; a resync input realigns the phase to a detected start bit. It sits between the system clock and the UART TX/RX state machines.

---
 rtl/baud_gen_frac_pkg.sv | 17 +
 rtl/baud_gen_frac_if.sv | 28 ++
 rtl/baud_gen_frac_acc.sv | 41 ++++
 rtl/baud_gen_frac.sv | 106 ++++++++++
 4 files changed

// File: rtl/baud_gen_frac_pkg.sv
// Shared defaults for the UART fractional baud generator, plus standard
// divisor settings for a 50 MHz system clock at 16x oversampling.
package baud_gen_frac_pkg;

    localparam int DW_DEF      = 16;
    localparam int FW_DEF      = 4;
    localparam int OSR_DEF     = 16;
    localparam int OSW_DEF     = 4;
    localparam int DIV_RST_DEF = 27;

    // 50e6 / (16 * baud) split into integer part and 1/16 fraction
    localparam logic [15:0] DIV_INT_115200  = 16'd27;
    localparam logic [3:0]  DIV_FRAC_115200 = 4'd2;
    localparam logic [15:0] DIV_INT_9600    = 16'd325;
    localparam logic [3:0]  DIV_FRAC_9600   = 4'd8;

endpackage

// File: rtl/baud_gen_frac_if.sv
// Control and tick bundle between the baud generator and the UART TX/RX.
interface baud_gen_frac_if #(
    parameter int DW  = 16,
    parameter int FW  = 4,
    parameter int OSW = 4
);
    logic          en;
    logic [DW-1:0] div_int;
    logic [FW-1:0] div_frac;
    logic          load;
    logic          resync;
    logic          os_tick;
    logic          half_tick;
    logic          bit_tick;
    logic          bit_clk;
    logic [OSW-1:0] os_cnt;
    logic          pending;

    modport master (
        output en, div_int, div_frac, load, resync,
        input  os_tick, half_tick, bit_tick, bit_clk, os_cnt, pending
    );

    modport slave (
        input  en, div_int, div_frac, load, resync,
        output os_tick, half_tick, bit_tick, bit_clk, os_cnt, pending
    );
endinterface

// File: rtl/baud_gen_frac_acc.sv
// Fraction accumulator: adds the fractional step on every os tick and
// stretches the following os period by one cycle on carry-out.
module baud_frac_acc #(
    parameter int FW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [FW-1:0] step,
    input  logic          tick,
    input  logic          clear,
    output logic          ext
);
    logic [FW-1:0] acc_q, acc_d;
    logic          ext_q, ext_d;
    logic [FW:0]   sum;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, step};
        acc_d = acc_q;
        ext_d = ext_q;
        if (clear) begin
            acc_d = '0;
            ext_d = 1'b0;
        end else if (tick) begin
            acc_d = sum[FW-1:0];
            ext_d = sum[FW];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            ext_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ext_q <= ext_d;
        end
    end

    assign ext = ext_q;
endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator: os/half/bit ticks and bit clock from a
// runtime-loadable N + F/2^FW divisor, with start-bit resync.
module baud_gen_frac
    import baud_gen_frac_pkg::*;
#(
    parameter int            DW      = DW_DEF,
    parameter int            FW      = FW_DEF,
    parameter int            OSR     = OSR_DEF,
    parameter int            OSW     = OSW_DEF,
    parameter logic [DW-1:0] DIV_RST = DW'(DIV_RST_DEF)
) (
    input logic             clk,
    input logic             rst,
    baud_gen_frac_if.slave  bus
);
    logic [DW-1:0]  n_act_q, n_act_d, n_shd_q, n_shd_d;
    logic [FW-1:0]  f_act_q, f_act_d, f_shd_q, f_shd_d;
    logic           pending_q, pending_d;
    logic [DW-1:0]  cnt_q, cnt_d;
    logic [OSW-1:0] os_cnt_q, os_cnt_d;
    logic           bit_clk_q, bit_clk_d;

    logic [DW-1:0]  n_eff;
    logic [DW:0]    last;
    logic           ext, os_tick, half_tick, bit_tick, apply;

    // Divisors 0 and 1 cannot form a count period, so they behave as 2
    assign n_eff     = (n_act_q < DW'(2)) ? DW'(2) : n_act_q;
    assign last      = {1'b0, n_eff} - (DW+1)'(1) + {{DW{1'b0}}, ext};
    assign os_tick   = bus.en & ~bus.resync & ({1'b0, cnt_q} == last);
    assign half_tick = os_tick & (os_cnt_q == OSW'(OSR/2 - 1));
    assign bit_tick  = os_tick & (os_cnt_q == OSW'(OSR - 1));
    assign apply     = pending_q & ~bus.resync & (os_tick | ~bus.en);

    baud_frac_acc #(.FW(FW)) u_acc (
        .clk   (clk),
        .rst   (rst),
        .step  (f_act_q),
        .tick  (os_tick),
        .clear (bus.resync | apply),
        .ext   (ext)
    );

    always_comb begin
        n_act_d   = n_act_q;
        f_act_d   = f_act_q;
        n_shd_d   = n_shd_q;
        f_shd_d   = f_shd_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        os_cnt_d  = os_cnt_q;
        bit_clk_d = bit_clk_q;

        if (apply) begin
            n_act_d   = n_shd_q;
            f_act_d   = f_shd_q;
            pending_d = 1'b0;
        end
        // A load coinciding with apply re-arms with the newer value
        if (bus.load) begin
            n_shd_d   = bus.div_int;
            f_shd_d   = bus.div_frac;
            pending_d = 1'b1;
        end

        if (bus.resync) begin
            cnt_d    = '0;
            os_cnt_d = '0;
        end else if (os_tick) begin
            cnt_d    = '0;
            os_cnt_d = os_cnt_q + OSW'(1);
            if (bit_tick) bit_clk_d = ~bit_clk_q;
        end else if (bus.en) begin
            cnt_d = cnt_q + DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_act_q   <= DIV_RST;
            f_act_q   <= '0;
            n_shd_q   <= '0;
            f_shd_q   <= '0;
            pending_q <= 1'b0;
            cnt_q     <= '0;
            os_cnt_q  <= '0;
            bit_clk_q <= 1'b0;
        end else begin
            n_act_q   <= n_act_d;
            f_act_q   <= f_act_d;
            n_shd_q   <= n_shd_d;
            f_shd_q   <= f_shd_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            os_cnt_q  <= os_cnt_d;
            bit_clk_q <= bit_clk_d;
        end
    end

    assign bus.os_tick   = os_tick;
    assign bus.half_tick = half_tick;
    assign bus.bit_tick  = bit_tick;
    assign bus.bit_clk   = bit_clk_q;
    assign bus.os_cnt    = os_cnt_q;
    assign bus.pending   = pending_q;
endmodule
